map_column_feeder: RTL and testbench

Upstream stage of the game datapath: streams the 100-bit wall columns of the current level from the map ROM into the scroller, replacing the hard-coded `nextwall`. A 2-entry prefetch buffer hides ROM read latency. After the last map column the block emits the all-zero end-marker column, which makes the datapath end the game. A scroll-rate tick tells the datapath when to shift.

---
 rtl/map_column_feeder.sv | 170 +++++++++++++++++
 tb/tb_map_column_feeder.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/map_column_feeder.sv
// map_column_feeder
//   Streams the wall columns of the current level from the map ROM into the
//   scroller. A 2-entry prefetch FIFO hides the one-cycle ROM read latency.
//   After the last map column an all-zero end-marker column is offered,
//   which the datapath uses to end the game. shift_tick paces the scroll.
//
//   Optional feature: define MAP_LOOP_EN to make the map repeat forever.
//   The fetch address then wraps, END is never entered, and map_done pulses
//   when column 0 is transferred on every lap after the first.
//
// Ports
//   clk, resetn      clock, asynchronous active-low reset
//   start            one-cycle pulse: restart the map at column 0
//   halt             level: not in game, flush and go idle (beats start)
//   rom_rd/rom_addr  ROM read strobe and address
//   rom_data         ROM word, valid the cycle after rom_rd
//   col_data/col_valid/col_ready  column stream to the datapath
//   shift_tick       one-cycle scroll pulse every TICK_DIV cycles
//   map_done         end marker on offer (loop build: lap pulse)
//   col_count        saturating count of transferred columns
//
// Handshake: a column moves on a rising edge where col_valid and col_ready
// are both high. While col_valid is high and col_ready low, col_data is held.
// col_ready is ignored while col_valid is low.
module map_column_feeder #(
   parameter int COL_W    = 100,
   parameter int ADDR_W   = 8,
   parameter int MAP_LEN  = 200,
   parameter int TICK_DIV = 2500000
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              start,
   input  logic              halt,
   output logic              rom_rd,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [COL_W-1:0]  rom_data,
   output logic [COL_W-1:0]  col_data,
   output logic              col_valid,
   input  logic              col_ready,
   output logic              shift_tick,
   output logic              map_done,
   output logic [ADDR_W-1:0] col_count
);

   localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
`ifdef MAP_LOOP_EN
   localparam logic [ADDR_W:0] LAST_A = (ADDR_W+1)'(MAP_LEN - 1);
`else
   localparam logic [ADDR_W:0] MAP_LEN_A = (ADDR_W+1)'(MAP_LEN);
`endif

   typedef enum logic [1:0] {S_IDLE, S_FETCH, S_END} state_t;

   state_t            state;
   logic [COL_W-1:0]  buf_data [2];
   logic              rd_ptr, wr_ptr;
   logic [1:0]        occ;
   logic              ret_v;        // ROM data returns this cycle
   logic [ADDR_W:0]   fetch_addr;   // one extra bit so MAP_LEN fits
   logic [TICK_W-1:0] tick_cnt;

   logic              pop, pop_fetch, addr_ok;
   logic [2:0]        level;
   logic [1:0]        occ_next;
   logic [ADDR_W:0]   addr_next;

`ifdef MAP_LOOP_EN
   // Tags the column fetched from address 0 on every lap after the first.
   logic              buf_flag [2];
   logic              ret_flag;
   logic              lapped;
`endif

   assign rom_addr = fetch_addr[ADDR_W-1:0];

   always_comb begin
      col_valid = (state == S_END) || (occ != 2'd0);
      pop       = col_valid & col_ready;
      pop_fetch = pop & (state == S_FETCH);
      // Buffer level after this edge if nothing new is issued: the word
      // returning from the ROM is counted, the word leaving is not.
      level     = {1'b0, occ} + {2'b00, ret_v} - {2'b00, pop_fetch};
      occ_next  = level[1:0];
`ifdef MAP_LOOP_EN
      addr_ok   = 1'b1;
      addr_next = (fetch_addr == LAST_A) ? '0 : fetch_addr + (ADDR_W+1)'(1);
      map_done  = pop & buf_flag[rd_ptr];
`else
      addr_ok   = (fetch_addr < MAP_LEN_A);
      addr_next = fetch_addr + (ADDR_W+1)'(1);
      map_done  = (state == S_END);
`endif
      rom_rd     = (state == S_FETCH) & ~halt & ~start & addr_ok & (level < 3'd2);
      col_data   = (state == S_FETCH && occ != 2'd0) ? buf_data[rd_ptr] : '0;
      shift_tick = (state != S_IDLE) && (tick_cnt == TICK_LAST);
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state       <= S_IDLE;
         buf_data[0] <= '0;
         buf_data[1] <= '0;
         rd_ptr      <= 1'b0;
         wr_ptr      <= 1'b0;
         occ         <= 2'd0;
         ret_v       <= 1'b0;
         fetch_addr  <= '0;
         tick_cnt    <= '0;
         col_count   <= '0;
      end else if (halt || start) begin
         // Flush: buffered and in-flight columns are dropped.
         state      <= halt ? S_IDLE : S_FETCH;
         rd_ptr     <= 1'b0;
         wr_ptr     <= 1'b0;
         occ        <= 2'd0;
         ret_v      <= 1'b0;
         fetch_addr <= '0;
         tick_cnt   <= '0;
         col_count  <= '0;
      end else begin
         if (state != S_IDLE) begin
            tick_cnt <= (tick_cnt == TICK_LAST) ? '0 : tick_cnt + TICK_W'(1);
            if (pop && col_count != '1)
               col_count <= col_count + ADDR_W'(1);
         end
         if (state == S_FETCH) begin
            if (ret_v) begin
               buf_data[wr_ptr] <= rom_data;
               wr_ptr           <= ~wr_ptr;
            end
            if (pop)
               rd_ptr <= ~rd_ptr;
            occ   <= occ_next;
            ret_v <= rom_rd;
            if (rom_rd)
               fetch_addr <= addr_next;
`ifndef MAP_LOOP_EN
            // Map exhausted, nothing in flight, last column leaving now.
            if (fetch_addr == MAP_LEN_A && !ret_v && occ_next == 2'd0)
               state <= S_END;
`endif
         end
      end
   end

`ifdef MAP_LOOP_EN
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         buf_flag[0] <= 1'b0;
         buf_flag[1] <= 1'b0;
         ret_flag    <= 1'b0;
         lapped      <= 1'b0;
      end else if (halt || start) begin
         ret_flag <= 1'b0;
         lapped   <= 1'b0;
      end else if (state == S_FETCH) begin
         if (ret_v)
            buf_flag[wr_ptr] <= ret_flag;
         if (rom_rd) begin
            ret_flag <= lapped && (fetch_addr == '0);
            if (fetch_addr == LAST_A)
               lapped <= 1'b1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_map_column_feeder.sv
module tb_map_column_feeder;

   localparam int COL_W    = 100;
   localparam int ADDR_W   = 8;
   localparam int MAP_LEN  = 4;
   localparam int TICK_DIV = 4;

   logic              clk = 1'b0;
   logic              resetn;
   logic              start, halt, col_ready;
   logic              rom_rd;
   logic [ADDR_W-1:0] rom_addr;
   logic [COL_W-1:0]  rom_data;
   logic [COL_W-1:0]  col_data;
   logic              col_valid, shift_tick, map_done;
   logic [ADDR_W-1:0] col_count;

   logic [COL_W-1:0]  exp_q[$];
   int                n_cmp = 0;
   int                n_err = 0;
   int                xfer_cnt = 0;
   int                done_pulses = 0;

   map_column_feeder #(
      .COL_W(COL_W), .ADDR_W(ADDR_W), .MAP_LEN(MAP_LEN), .TICK_DIV(TICK_DIV)
   ) dut (
      .clk(clk), .resetn(resetn), .start(start), .halt(halt),
      .rom_rd(rom_rd), .rom_addr(rom_addr), .rom_data(rom_data),
      .col_data(col_data), .col_valid(col_valid), .col_ready(col_ready),
      .shift_tick(shift_tick), .map_done(map_done), .col_count(col_count)
   );

   // clock / reset block
   always #5 clk = ~clk;

   function automatic logic [COL_W-1:0] word(input int a);
      logic [7:0] b;
      b = a[7:0];
      return {b ^ 8'hA5, 84'h123456789ABCDEF012345, b};
   endfunction

   // ROM model: registered read, data valid the cycle after rom_rd
   always @(posedge clk)
      rom_data <= rom_rd ? word(int'(rom_addr)) : '0;

   task automatic check(input string tag, input logic [COL_W-1:0] obs,
                        input logic [COL_W-1:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // driver tasks
   task automatic adv();
      @(posedge clk);
      #2;
   endtask

   task automatic push_map();
      for (int a = 0; a < MAP_LEN; a++) exp_q.push_back(word(a));
   endtask

   task automatic pulse_start();
      start = 1'b1;
      adv();
      start = 1'b0;
   endtask

   task automatic wait_done(input string tag);
      int n = 0;
      while (!map_done && n < 40) begin
         adv();
         n++;
      end
      check(tag, map_done, 1'b1);
   endtask

   // scoreboard: every transfer is checked against the expected queue
   always @(negedge clk) begin
      if (resetn && col_valid && col_ready) begin
`ifndef MAP_LOOP_EN
         if (map_done) check("end_marker", col_data, '0);
         else if (exp_q.size() == 0) check("xfer_unexpected", col_valid, 1'b0);
         else check("xfer_data", col_data, exp_q.pop_front());
`else
         if (map_done) begin
            check("loop_done_idx", xfer_cnt, 4);
            done_pulses++;
         end
         if (exp_q.size() == 0) check("xfer_unexpected", col_valid, 1'b0);
         else check("xfer_data", col_data, exp_q.pop_front());
`endif
         xfer_cnt++;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      resetn = 1'b0; start = 1'b0; halt = 1'b0; col_ready = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      check("rst_rom_rd", rom_rd, 1'b0);
      check("rst_rom_addr", rom_addr, '0);
      check("rst_col_valid", col_valid, 1'b0);
      check("rst_col_data", col_data, '0);
      check("rst_map_done", map_done, 1'b0);
      check("rst_tick", shift_tick, 1'b0);
      check("rst_count", col_count, '0);
      resetn = 1'b1;
      adv();

`ifndef MAP_LOOP_EN
      // Single pass with col_ready high: reads 0..3 back to back, end marker
      col_ready = 1'b1;
      push_map();
      pulse_start();
      for (int c = 1; c <= 7; c++) begin
         #1;
         check("t1_rom_rd", rom_rd, (c <= 4));
         if (c <= 4) check("t1_rom_addr", rom_addr, c - 1);
         check("t1_col_valid", col_valid, (c >= 3));
         if (c >= 3 && c <= 6) check("t1_col_data", col_data, word(c - 3));
         check("t1_map_done", map_done, (c == 7));
         check("t1_tick", shift_tick, (c % 4 == 0));
         adv();
      end
      col_ready = 1'b0;
      #1;
      check("t1_count", col_count, 5);
      check("t1_end_hold", map_done, 1'b1);
      check("t1_tick8", shift_tick, 1'b1);

      // Back-pressure: only two reads, head word held
      begin
         int n_rd = 0;
         pulse_start();
         for (int c = 1; c <= 12; c++) begin
            #1;
            if (rom_rd) n_rd++;
            if (c >= 3) check("t2_hold_data", col_data, word(0));
            if (c < 12) adv();
         end
         check("t2_rd_count", n_rd, 2);
      end
      push_map();
      col_ready = 1'b1;
      wait_done("t2_done");

      // halt mid-stream, then restart: no stale data
      col_ready = 1'b0;
      pulse_start();
      repeat (3) adv();
      halt = 1'b1;
      for (int c = 0; c < 3; c++) begin
         adv();
         #1;
         check("t3_halt_valid", col_valid, 1'b0);
         check("t3_halt_rd", rom_rd, 1'b0);
      end
      halt = 1'b0;
      push_map();
      col_ready = 1'b1;
      pulse_start();
      #1;
      check("t3_rd", rom_rd, 1'b1);
      check("t3_addr", rom_addr, '0);
      adv();
      adv();
      #1;
      check("t3_valid", col_valid, 1'b1);
      check("t3_first", col_data, word(0));
      wait_done("t3_done");

      // start and halt together: halt wins
      start = 1'b1;
      halt  = 1'b1;
      adv();
      start = 1'b0;
      halt  = 1'b0;
      #1;
      check("t4_valid", col_valid, 1'b0);
      check("t4_done", map_done, 1'b0);
      check("t4_count", col_count, '0);
      for (int c = 0; c < 4; c++) begin
         check("t4_rd", rom_rd, 1'b0);
         check("t4_tick", shift_tick, 1'b0);
         adv();
         #1;
      end

      // asynchronous reset mid-stream, then a clean restart
      col_ready = 1'b0;
      pulse_start();
      repeat (3) adv();
      #1;
      check("t5_pre_valid", col_valid, 1'b1);
      check("t5_pre_tick", shift_tick, 1'b1);
      resetn = 1'b0;
      #1;
      check("t5_valid", col_valid, 1'b0);
      check("t5_rd", rom_rd, 1'b0);
      check("t5_addr", rom_addr, '0);
      check("t5_data", col_data, '0);
      check("t5_tick", shift_tick, 1'b0);
      adv();
      resetn = 1'b1;
      adv();
      push_map();
      col_ready = 1'b1;
      pulse_start();
      #1;
      check("t5_rd0", rom_rd, 1'b1);
      check("t5_addr0", rom_addr, '0);
      adv();
      adv();
      #1;
      check("t5_first", col_data, word(0));
      wait_done("t5_done");
      col_ready = 1'b0;
      adv();
`else
      // Looping map: 0..3 twice, map_done only on the second column 0
      push_map();
      push_map();
      col_ready = 1'b1;
      pulse_start();
      begin
         int n = 0;
         while (xfer_cnt < 8 && n < 60) begin
            adv();
            n++;
         end
         col_ready = 1'b0;
         check("loop_xfers", xfer_cnt, 8);
      end
      repeat (3) adv();
      check("loop_pulses", done_pulses, 1);
      check("loop_no_end", col_data == '0 && col_valid, 1'b0);
`endif
      check("queue_drained", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
